// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Optional checksum support is controlled by the IMEM_LOADER_CHECKSUM_EN macro.
package imem_loader_pkg;

  localparam int WORD_BYTES     = 4;
  localparam int LEN_BYTES      = 2;
  localparam int ADDR_W_DEFAULT = 12;
  localparam int LEN_W_DEFAULT  = LEN_BYTES * 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
    CHK    = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_e;

  // States in which the loader consumes stream bytes.
  function automatic logic is_rx_state(input state_e s);
    return (s == LEN_HI) || (s == LEN_LO) || (s == DATA) || (s == CHK);
  endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Assembles big-endian stream bytes into 32-bit words.
// word_valid_o pulses for one cycle, the cycle after the last byte of a word.
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        last_byte_o,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);

  logic [1:0]  cnt_q;
  logic [23:0] sr_q;
  logic        word_valid_q;
  logic [31:0] word_q;

  assign last_byte_o  = (cnt_q == LAST_IDX);
  assign word_valid_o = word_valid_q;
  assign word_o       = word_q;

  // Shift bytes in MSB first; emit the full word on the final byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= 2'd0;
      sr_q         <= 24'd0;
      word_valid_q <= 1'b0;
      word_q       <= 32'd0;
    end else begin
      word_valid_q <= 1'b0;
      if (clr_i) begin
        cnt_q <= 2'd0;
        sr_q  <= 24'd0;
      end else if (byte_valid_i) begin
        if (cnt_q == LAST_IDX) begin
          word_q       <= {sr_q, byte_i};
          word_valid_q <= 1'b1;
          cnt_q        <= 2'd0;
          sr_q         <= 24'd0;
        end else begin
          sr_q  <= {sr_q[15:0], byte_i};
          cnt_q <= cnt_q + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: parses a length-prefixed byte frame and writes
// words into the instruction memory while holding the CPU in reset.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int LEN_W  = LEN_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [LEN_W:0] DEPTH_L = (LEN_W + 1)'(1 << ADDR_W);

  state_e            state_q, state_d;
  logic              in_ready_q, cpu_hold_q, busy_q, done_q, err_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [ADDR_W:0]   words_loaded_q, wl_inc_s;
  logic [LEN_W-1:0]  len_q, len_s;
  logic              take_s, start_ok_s, data_byte_s, last_byte_s;
  logic              word_take_s, len_match_s;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        chk_q;
`endif

  assign take_s      = in_valid && in_ready_q;
  assign start_ok_s  = start && !busy_q &&
                       ((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));
  assign data_byte_s = take_s && (state_q == DATA);
  assign word_take_s = data_byte_s && last_byte_s;
  assign wl_inc_s    = words_loaded_q + {{ADDR_W{1'b0}}, 1'b1};
  assign len_match_s = (LEN_W'(wl_inc_s) == len_q);
  assign len_s       = {len_q[LEN_W-9:0], in_data};

  assign in_ready     = in_ready_q;
  assign mem_addr     = mem_addr_q;
  assign cpu_hold     = cpu_hold_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign words_loaded = words_loaded_q;

  imem_word_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (start_ok_s),
    .byte_valid_i (data_byte_s),
    .byte_i       (in_data),
    .last_byte_o  (last_byte_s),
    .word_valid_o (mem_we),
    .word_o       (mem_wdata)
  );

  // Next-state decode for the frame parser.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start_ok_s) state_d = LEN_HI;
        else            state_d = state_q;
      end
      LEN_HI: begin
        if (take_s) state_d = LEN_LO;
        else        state_d = state_q;
      end
      LEN_LO: begin
        if (take_s) begin
          if (len_s == {LEN_W{1'b0}}) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = CHK;
`else
            state_d = DONE;
`endif
          end else if ({1'b0, len_s} > DEPTH_L) begin
            state_d = ERR;
          end else begin
            state_d = DATA;
          end
        end else begin
          state_d = state_q;
        end
      end
      DATA: begin
        if (word_take_s && len_match_s) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = CHK;
`else
          state_d = DONE;
`endif
        end else begin
          state_d = state_q;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: begin
        if (take_s) begin
          if (in_data == chk_q) state_d = DONE;
          else                  state_d = ERR;
        end else begin
          state_d = state_q;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State register plus all registered status/control outputs.
  // DONE/ERR entry effects land on the first cycle spent in that state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      in_ready_q     <= 1'b0;
      cpu_hold_q     <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      mem_addr_q     <= {ADDR_W{1'b0}};
      words_loaded_q <= {(ADDR_W + 1){1'b0}};
      len_q          <= {LEN_W{1'b0}};
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_q          <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      in_ready_q <= is_rx_state(state_d);
      done_q     <= 1'b0;

      if (start_ok_s) begin
        err_q          <= 1'b0;
        words_loaded_q <= {(ADDR_W + 1){1'b0}};
        cpu_hold_q     <= 1'b1;
        busy_q         <= 1'b1;
        len_q          <= {LEN_W{1'b0}};
      end else if (busy_q && ((state_q == DONE) || (state_q == ERR))) begin
        busy_q     <= 1'b0;
        cpu_hold_q <= 1'b0;
        done_q     <= (state_q == DONE);
        if (state_q == ERR) err_q <= 1'b1;
      end

      if (take_s && ((state_q == LEN_HI) || (state_q == LEN_LO))) begin
        len_q <= len_s;
      end

      // The write address is the pre-increment count, so it never wraps.
      if (word_take_s) begin
        words_loaded_q <= wl_inc_s;
        mem_addr_q     <= words_loaded_q[ADDR_W-1:0];
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      if (start_ok_s) begin
        chk_q <= 8'd0;
      end else if (data_byte_s) begin
        chk_q <= chk_q ^ in_data;
      end
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst, start, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, mem_we, cpu_hold, busy, done, err;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [12:0] words_loaded;

  imem_loader dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Write / done monitor, sampled on the falling edge.
  logic [11:0] wr_addr [0:63];
  logic [31:0] wr_data [0:63];
  int          wr_cyc  [0:63];
  int          wr_n = 0;
  int          done_n = 0;
  int          done_cyc = 0;
  always @(negedge clk) begin
    if (mem_we && wr_n < 64) begin
      wr_addr[wr_n] <= mem_addr;
      wr_data[wr_n] <= mem_wdata;
      wr_cyc[wr_n]  <= cyc;
      wr_n          <= wr_n + 1;
    end
    if (done) begin
      done_n   <= done_n + 1;
      done_cyc <= cyc;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int last_hs  = 0;
  logic [7:0] xor_acc = 8'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int g;
    int w;
    bit ok;
    g = (gap > 0) ? int'($urandom_range(0, gap)) : 0;
    in_valid = 1'b0;
    repeat (g) tick(1);
    in_data  = b;
    in_valid = 1'b1;
    w  = 0;
    ok = 1'b0;
    while (!ok && w < 20) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      else w++;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $error("FAIL handshake_timeout: observed in_ready %0b expected 1", in_ready);
    end
    last_hs = cyc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    xor_acc  = xor_acc ^ b;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic send_hdr(input logic [15:0] n);
    send_byte(n[15:8], 0);
    send_byte(n[7:0], 0);
    xor_acc = 8'd0;
  endtask

  task automatic send_word(input logic [31:0] wd, input int gap);
    send_byte(wd[31:24], gap);
    send_byte(wd[23:16], gap);
    send_byte(wd[15:8], gap);
    send_byte(wd[7:0], gap);
  endtask

  task automatic send_cks();
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(xor_acc, 0);
`endif
  endtask

  logic [31:0] prog5 [0:4] = '{32'h0020000F, 32'h0421000F, 32'h08400004, 32'h90610002, 32'h0FE30007};
  logic [31:0] prog3 [0:2] = '{32'hAABBCCDD, 32'h11223344, 32'hDEADBEEF};
  logic [31:0] prog2 [0:1] = '{32'hCAFEF00D, 32'h0BADC0DE};
  int hs4 [0:7];
  int wbase, dbase;
  logic [31:0] wtmp;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'd0;
    tick(3);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_cpu_hold", cpu_hold, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_words_loaded", words_loaded, 0);
    rst = 1'b0;
    tick(1);

    // Five-word program
    wbase = wr_n; dbase = done_n;
    do_start();
    chk("t1_busy", busy, 1);
    chk("t1_cpu_hold", cpu_hold, 1);
    chk("t1_in_ready", in_ready, 1);
    send_hdr(16'd5);
    for (int i = 0; i < 5; i++) begin
      send_word(prog5[i], 0);
      hs4[i] = last_hs;
    end
    send_cks();
    tick(4);
    chk("t1_nwrites", wr_n - wbase, 5);
    for (int i = 0; i < 5; i++) begin
      chk("t1_addr", {20'd0, wr_addr[wbase + i]}, i);
      chk("t1_data", wr_data[wbase + i], prog5[i]);
      chk("t1_latency", wr_cyc[wbase + i], hs4[i] + 1);
    end
    chk("t1_done_count", done_n - dbase, 1);
    chk("t1_done_time", done_cyc, last_hs + 2);
    chk("t1_words_loaded", words_loaded, 5);
    chk("t1_cpu_hold_after", cpu_hold, 0);
    chk("t1_busy_after", busy, 0);
    chk("t1_err", err, 0);
    chk("t1_in_ready_after", in_ready, 0);

    // Empty frame
    wbase = wr_n; dbase = done_n;
    do_start();
    send_hdr(16'd0);
    send_cks();
    tick(4);
    chk("t2_nwrites", wr_n - wbase, 0);
    chk("t2_done_count", done_n - dbase, 1);
    chk("t2_done_time", done_cyc, last_hs + 2);
    chk("t2_err", err, 0);
    chk("t2_words_loaded", words_loaded, 0);

    // Oversized length
    wbase = wr_n; dbase = done_n;
    do_start();
    send_hdr(16'h1001);
    tick(3);
    chk("t3_err", err, 1);
    chk("t3_cpu_hold", cpu_hold, 0);
    chk("t3_busy", busy, 0);
    chk("t3_nwrites", wr_n - wbase, 0);
    chk("t3_no_done", done_n - dbase, 0);
    do_start();
    chk("t3_err_cleared", err, 0);
    chk("t3_busy_again", busy, 1);

    // Three words with random gaps; a stray start mid-word is ignored
    wbase = wr_n; dbase = done_n;
    send_hdr(16'd3);
    for (int i = 0; i < 12; i++) begin
      wtmp = prog3[i / 4];
      send_byte(wtmp[31 - 8 * (i % 4) -: 8], 3);
      if (i % 4 == 3) hs4[i / 4] = last_hs;
      if (i == 5) begin
        do_start();
        chk("t4_start_ignored_busy", busy, 1);
      end
    end
    send_cks();
    tick(4);
    chk("t4_nwrites", wr_n - wbase, 3);
    for (int i = 0; i < 3; i++) begin
      chk("t4_addr", {20'd0, wr_addr[wbase + i]}, i);
      chk("t4_data", wr_data[wbase + i], prog3[i]);
      chk("t4_latency", wr_cyc[wbase + i], hs4[i] + 1);
    end
    chk("t4_done_count", done_n - dbase, 1);
    chk("t4_words_loaded", words_loaded, 3);
    chk("t4_err", err, 0);

    // Reset in the middle of the second word
    wbase = wr_n;
    do_start();
    send_hdr(16'd4);
    send_word(32'h01020304, 0);
    send_byte(8'h05, 0);
    send_byte(8'h06, 0);
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("t5_nwrites", wr_n - wbase, 1);
    chk("t5_addr", {20'd0, wr_addr[wbase]}, 0);
    chk("t5_data", wr_data[wbase], 32'h01020304);
    chk("t5_busy", busy, 0);
    chk("t5_cpu_hold", cpu_hold, 0);
    chk("t5_in_ready", in_ready, 0);
    chk("t5_words_loaded", words_loaded, 0);
    chk("t5_mem_addr", mem_addr, 0);
    chk("t5_mem_wdata", mem_wdata, 0);
    wbase = wr_n; dbase = done_n;
    do_start();
    send_hdr(16'd2);
    send_word(prog2[0], 0);
    send_word(prog2[1], 0);
    send_cks();
    tick(4);
    chk("t5b_nwrites", wr_n - wbase, 2);
    chk("t5b_addr0", {20'd0, wr_addr[wbase]}, 0);
    chk("t5b_data0", wr_data[wbase], prog2[0]);
    chk("t5b_addr1", {20'd0, wr_addr[wbase + 1]}, 1);
    chk("t5b_data1", wr_data[wbase + 1], prog2[1]);
    chk("t5b_done_count", done_n - dbase, 1);
    chk("t5b_words_loaded", words_loaded, 2);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Good and bad checksum
    wbase = wr_n; dbase = done_n;
    do_start();
    send_hdr(16'd1);
    send_word(32'h12345678, 0);
    send_byte(8'h08, 0);
    tick(4);
    chk("t6_done_count", done_n - dbase, 1);
    chk("t6_err", err, 0);
    chk("t6_data", wr_data[wbase], 32'h12345678);
    wbase = wr_n; dbase = done_n;
    do_start();
    send_hdr(16'd1);
    send_word(32'h12345678, 0);
    send_byte(8'h09, 0);
    tick(4);
    chk("t6b_err", err, 1);
    chk("t6b_no_done", done_n - dbase, 0);
    chk("t6b_nwrites", wr_n - wbase, 1);
    chk("t6b_data", wr_data[wbase], 32'h12345678);
    chk("t6b_cpu_hold", cpu_hold, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the CPU instruction memory: receives a framed byte stream and writes 32-bit instruction words into the memory's write port.
- Sits between a host link (UART/debug byte source) and the instruction memory.
- Holds the CPU in reset via cpu_hold while a program is being loaded.

Parameters:
ADDR_W, 12, word address width; memory depth DEPTH = 2**ADDR_W words (4096)
LEN_W, 16, width of the word-count header field (always sent as 2 bytes)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  single-cycle pulse; begins a new load frame
in_data  input  8  stream byte
in_valid  input  1  in_data valid
in_ready  output  1  loader accepts a byte this cycle
mem_we  output  1  instruction memory write strobe, one cycle per word
mem_addr  output  ADDR_W  word address of the write
mem_wdata  output  32  instruction word
cpu_hold  output  1  hold CPU in reset while loading
busy  output  1  frame in progress
done  output  1  one-cycle pulse on successful frame end
err  output  1  sticky frame error, cleared by start or rst
words_loaded  output  ADDR_W+1  count of words written in the current/last frame

Behaviour:
- Reset: state IDLE. in_ready, mem_we, cpu_hold, busy, done and err are 0. mem_addr, mem_wdata and words_loaded are 0.
- Handshake: a byte is taken when in_valid && in_ready. in_ready=1 only in LEN_HI, LEN_LO, DATA and CHK. No backpressure stalls exist inside the block.
- Frame format: LEN_HI, LEN_LO (N, big-endian), then N words of 4 bytes each, most significant byte first, then (CHK only) 1 checksum byte.
- FSM transitions:
  - IDLE/DONE/ERR -> LEN_HI on start. In the same cycle: err<=0, words_loaded<=0, byte and word counters <=0, cpu_hold<=1, busy<=1.
  - LEN_HI -> LEN_LO on a byte handshake.
  - LEN_LO on a byte handshake: N==0 -> DONE; N>DEPTH -> ERR; otherwise -> DATA.
  - DATA: bytes shift into the word register. On the 4th byte handshake, the next cycle has mem_we=1, mem_addr=word index (starting at 0), mem_wdata=assembled word, and words_loaded increments in that same cycle. Write latency is 1 cycle after the 4th byte. After the Nth word the FSM goes to CHK if the feature is enabled, otherwise to DONE.
  - DONE entry: done=1 for exactly 1 cycle; cpu_hold<=0, busy<=0.
  - ERR entry: err<=1, cpu_hold<=0, busy<=0. Words already written stay in memory.
- start while busy is ignored and does not restart the frame.
- in_valid=0 mid-word: the partial word is held indefinitely. There is no timeout.
- N==DEPTH is legal. The last write goes to address DEPTH-1; the address never wraps.
- rst mid-frame: immediate return to IDLE with all outputs at reset values. Any partial word is discarded.
- mem_we is never asserted outside DATA, or the cycle following it.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - A running XOR of all data bytes (header excluded), cleared on start.
  - After the last data byte the FSM enters CHK and accepts 1 byte.
  - Byte equals the XOR -> DONE. Mismatch -> ERR.
  - When N==0 the checksum byte is still expected and must equal 0x00.
- Not defined: CHK state and XOR logic are absent, and the frame ends after the last data byte.

Decomposition:
- Package imem_loader_pkg holds:
  - the state enum (IDLE, LEN_HI, LEN_LO, DATA, CHK, DONE, ERR)
  - WORD_BYTES=4
  - LEN_BYTES=2
  - the default ADDR_W
- One natural sub-module, imem_word_packer: byte shift register plus a 2-bit byte counter. It outputs word_valid (1-cycle) and word.
- The FSM, address counter and checksum stay in imem_loader.

Test Plan:
- Load 5 words: start, bytes 00 05, then 0020000F 0421000F 08400004 90610002 0FE30007 -> writes at addr 0..4 with those words, done pulse, words_loaded=5, cpu_hold low after.
- Header 00 00 -> no mem_we, done pulse 2 cycles after the second header byte is accepted, err=0.
- Header 10 01 (N=4097 > 4096) -> err=1, no writes, cpu_hold=0. A following start clears err.
- Random in_valid gaps (~50% duty) during a 3-word frame -> identical writes and addresses. mem_we occurs exactly 1 cycle after each 4th byte.
- rst asserted after 6 data bytes -> IDLE, only 1 write occurred. A new frame starting at addr 0 loads correctly.
- (IMEM_LOADER_CHECKSUM_EN) Frame N=1, word 12345678, checksum 0x08 -> done. Same frame with checksum 0x09 -> err=1, word still written.
